// File: rtl/apu_pkg.sv
// Shared definitions for the pulse bank: duty table, duty type, step width.
package apu_pkg;

    localparam int unsigned STEP_W = 3;

    typedef logic [1:0]        duty_t;
    typedef logic [STEP_W-1:0] step_t;

    localparam step_t STEP_LAST = '1;

    // Index 0 is the rightmost entry; bit 7 of each pattern is step 0.
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b10011111,
        8'b01111000,
        8'b01100000,
        8'b01000000
    };

    function automatic logic duty_bit(input duty_t duty, input step_t step);
        logic [7:0] pat;
        pat = DUTY_TABLE[duty];
        return pat[3'd7 - step];
    endfunction

endpackage

// File: rtl/apu_pulse_bank_if.sv
// Config-write and sample-stream signals of the pulse bank.
interface apu_pulse_bank_if #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PERIOD_W = 11,
    parameter int unsigned LEN_W    = 6
);
    import apu_pkg::*;

    localparam int unsigned SUM_W = $clog2(CHANNELS + 1);

    logic [2:0]          cfg_chan;
    logic [PERIOD_W-1:0] cfg_period;
    duty_t               cfg_duty;
    logic [LEN_W-1:0]    cfg_len;
    logic                cfg_valid;
    logic                cfg_ready;
    logic                cfg_err;
    logic [CHANNELS-1:0] out_bits;
    logic [SUM_W-1:0]    out_sum;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output cfg_chan, cfg_period, cfg_duty, cfg_len, cfg_valid, out_ready,
        input  cfg_ready, cfg_err, out_bits, out_sum, out_valid
    );

    modport slave (
        input  cfg_chan, cfg_period, cfg_duty, cfg_len, cfg_valid, out_ready,
        output cfg_ready, cfg_err, out_bits, out_sum, out_valid
    );

endinterface

// File: rtl/apu_pulse_channel.sv
// One pulse channel: period timer, 8-step duty sequencer, length counter.
module apu_pulse_channel
    import apu_pkg::*;
#(
    parameter int unsigned PERIOD_W = 11,
    parameter int unsigned LEN_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                wr_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  duty_t               duty_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                bit_o,
    output logic                bit_next_o
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] timer_q,  timer_d;
    duty_t               duty_q,   duty_d;
    logic [LEN_W-1:0]    len_q,    len_d;
    step_t               step_q,   step_d;
    logic                active_q, active_d;
    logic                bit_q,    bit_d;

    always_comb begin
        period_d = period_q;
        timer_d  = timer_q;
        duty_d   = duty_q;
        len_d    = len_q;
        step_d   = step_q;
        active_d = active_q;
        // A write overrides any tick arriving in the same cycle.
        if (wr_i) begin
            period_d = period_i;
            duty_d   = duty_i;
            len_d    = len_i;
            timer_d  = period_i;
            step_d   = '0;
            active_d = 1'b1;
        end else if (tick_i && active_q && (period_q != '0)) begin
            if (timer_q == '0) begin
                timer_d = period_q;
                step_d  = step_q + 1'b1;
                if ((step_q == STEP_LAST) && (len_q != '0)) begin
                    len_d = len_q - 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        active_d = 1'b0;
                        timer_d  = timer_q;
                    end
                end
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
        bit_d = active_d && (period_d != '0) && duty_bit(duty_d, step_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            timer_q  <= '0;
            duty_q   <= '0;
            len_q    <= '0;
            step_q   <= '0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            timer_q  <= timer_d;
            duty_q   <= duty_d;
            len_q    <= len_d;
            step_q   <= step_d;
            active_q <= active_d;
            bit_q    <= bit_d;
        end
    end

    assign bit_o      = bit_q;
    assign bit_next_o = bit_d;

endmodule

// File: rtl/apu_pulse_bank.sv
// Bank of pulse channels: write decode, error flag, sample handshake, popcount.
module apu_pulse_bank
    import apu_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PERIOD_W = 11,
    parameter int unsigned LEN_W    = 6
) (
    input logic             clk,
    input logic             rst_n,
    apu_pulse_bank_if.slave bus
);

    localparam int unsigned SUM_W = $clog2(CHANNELS + 1);

    logic                valid_q;
    logic                ready_q;
    logic                err_q, err_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [CHANNELS-1:0] bits_cur;
    logic [CHANNELS-1:0] bits_next;
    logic                tick;
    logic                accept;

    assign tick   = valid_q && bus.out_ready;
    assign accept = bus.cfg_valid && ready_q;
    assign err_d  = accept && ({1'b0, bus.cfg_chan} >= 4'(CHANNELS));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        apu_pulse_channel #(
            .PERIOD_W (PERIOD_W),
            .LEN_W    (LEN_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_i     (tick),
            .wr_i       (accept && (bus.cfg_chan == 3'(g))),
            .period_i   (bus.cfg_period),
            .duty_i     (bus.cfg_duty),
            .len_i      (bus.cfg_len),
            .bit_o      (bits_cur[g]),
            .bit_next_o (bits_next[g])
        );
    end

    // Count the channels' next levels so the sum lands on the same edge as the bits.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            sum_d = sum_d + SUM_W'(bits_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            err_q   <= err_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.cfg_ready = ready_q;
    assign bus.cfg_err   = err_q;
    assign bus.out_valid = valid_q;
    assign bus.out_bits  = bits_cur;
    assign bus.out_sum   = sum_q;

endmodule

// File: doc/apu_pulse_bank.md
APU_PULSE_BANK -- requirements
Module: apu_pulse_bank

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent pulse channels, 1..8.
REQ-002 Parameter PERIOD_W, default 11: timer reload width in bits.
REQ-003 Parameter LEN_W, default 6: length-counter width in bits.
REQ-004 clk  input  1  single clock; all state is on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 cfg_chan  input  3  target channel index of a config write.
REQ-007 cfg_period  input  PERIOD_W  timer reload value.
REQ-008 cfg_duty  input  2  duty pattern select.
REQ-009 cfg_len  input  LEN_W  length count; 0 means continuous.
REQ-010 cfg_valid  input  1  config write offered.
REQ-011 cfg_ready  output  1  config write accepted when high together with cfg_valid.
REQ-012 cfg_err  output  1  one-cycle pulse on acceptance with cfg_chan >= CHANNELS.
REQ-013 out_bits  output  CHANNELS  per-channel pulse level.
REQ-014 out_sum  output  clog2(CHANNELS+1)  count of high bits in out_bits.
REQ-015 out_valid  output  1  sample offered.
REQ-016 out_ready  input  1  sample consumer ready.

Function
REQ-017 Tick = out_valid && out_ready; all channel timers, sequencers and length counters advance only on a tick, never otherwise.
REQ-018 out_valid SHALL be 0 in reset and 1 from the first clock edge after reset release onward.
REQ-019 cfg_ready SHALL be 0 in reset and 1 otherwise; every write is single-cycle, with no backpressure.
REQ-020 Write to channel c: period[c], duty[c] and len[c] loaded; timer[c] set to cfg_period; step[c] set to 0; active[c] set to 1.
REQ-021 Write with cfg_chan >= CHANNELS: no state change; cfg_err high the next cycle for one cycle.
REQ-022 On a tick, each active channel with period != 0 behaves as follows: if timer == 0, the timer reloads to period and step advances modulo 8; otherwise the timer decrements by 1.
REQ-023 Duty patterns, with step 0 as the leftmost bit: 0 = 01000000, 1 = 01100000, 2 = 01111000, 3 = 10011111.
REQ-024 out_bits[c] = pattern[duty[c]][step[c]] when active[c] and period[c] != 0; otherwise 0.
REQ-025 Length counter: when len[c] != 0 and step wraps 7->0 on a tick, len decrements; when it reaches 0, active[c] clears, the timer freezes and the output goes to 0.
REQ-026 len[c] == 0 at write time means continuous; the channel never self-mutes.
REQ-027 A config write and a tick to the same channel in the same cycle: the write wins; the tick effect on that channel is discarded.
REQ-028 out_bits and out_sum are registered; they change only on the edge after a tick or write, with one cycle latency.
REQ-029 out_bits and out_sum SHALL hold stable while out_valid && !out_ready.
REQ-030 Timer and step wrap without overflow; the period reload is exact with no width truncation (period + 1 ticks per step).

Reset
REQ-031 Asserting rst_n low at any time SHALL immediately clear all period, duty, len, timer, step and active state to 0.
REQ-032 While rst_n is low, out_bits = 0, out_sum = 0, out_valid = 0, cfg_ready = 0 and cfg_err = 0.
REQ-033 A config write in flight at reset assertion is lost; there is no partial update.

Structure
REQ-034 Shared package apu_pkg holds the duty-pattern table constant, the 2-bit duty typedef, and the step-width constant (3).
REQ-035 A per-channel sub-module, apu_pulse_channel (timer, sequencer, length counter, write port), SHALL be instantiated CHANNELS times by a generate loop.
REQ-036 The bank top holds the write decode, cfg_err, the out_valid register and the out_sum popcount.

Verification
REQ-037 Reset release, write ch0 period=1 duty=2 len=0, out_ready=1 held -> out_bits[0] sequence 0,0,1,1,1,1,1,1,1,1,0,0... (2 ticks per step), repeating every 16 ticks.
REQ-038 Write ch1 duty=0 len=1 period=0 -> out_bits[1] stays 0 and active stays set; then write period=3 len=1 -> exactly one 32-tick sequence, then the channel is permanently 0.
REQ-039 out_ready toggled 1,0,0,1 with all 3 channels running -> state advances exactly twice, and outputs are held during the stalls.
REQ-040 Write ch2 in the same cycle as the ch2 timer reaches 0 -> the new period loads, step = 0, and no step advance occurs.
REQ-041 Write cfg_chan=5 with CHANNELS=3 -> cfg_err pulses for one cycle and all channel outputs are unchanged.
REQ-042 rst_n pulsed low mid-sequence for a half-cycle -> outputs are 0 immediately, and out_valid returns to 1 the first edge after release.
